// File: rtl/comb_sweep_ctrl.sv
// Sweeps a 4-input combinational unit through all 16 input vectors, captures
// both outputs as truth tables and scores them against start-time expected masks.
module comb_sweep_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] exp_f1,
  input  logic [15:0] exp_f2,
  input  logic        f1,
  input  logic        f2,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt_f1,
  output logic [15:0] tt_f2,
  output logic [5:0]  err_cnt,
  output logic        pass
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("comb_sweep_ctrl: SETTLE must be in 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DONE} state_t;

  localparam logic [3:0] WLAST = 4'(SETTLE - 1);

  state_t      state;
  logic [3:0]  idx;
  logic [3:0]  wcnt;
  logic [15:0] exp1_q;
  logic [15:0] exp2_q;
  logic [1:0]  miss;

  // Per-vector mismatch contribution: 0..2, added into a 6-bit count that tops out at 32.
  assign miss = {1'b0, f1 != exp1_q[idx]} + {1'b0, f2 != exp2_q[idx]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      wcnt         <= '0;
      exp1_q       <= '0;
      exp2_q       <= '0;
      {a, b, c, d} <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      tt_f1        <= '0;
      tt_f2        <= '0;
      err_cnt      <= '0;
      pass         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            exp1_q       <= exp_f1;
            exp2_q       <= exp_f2;
            tt_f1        <= '0;
            tt_f2        <= '0;
            err_cnt      <= '0;
            pass         <= 1'b0;
            idx          <= '0;
            wcnt         <= '0;
            {a, b, c, d} <= '0;
            busy         <= 1'b1;
            state        <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          wcnt <= wcnt + 4'd1;
          if (wcnt == WLAST) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          tt_f1[idx] <= f1;
          tt_f2[idx] <= f2;
          err_cnt    <= err_cnt + {4'b0, miss};
          if (idx == 4'd15) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx          <= idx + 4'd1;
            wcnt         <= '0;
            {a, b, c, d} <= idx + 4'd1;
            state        <= S_SETTLE;
          end
        end
        S_DONE: begin
          // err_cnt already includes the last vector here.
          pass  <= (err_cnt == 6'd0);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
